// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared constants and FSM encoding for the gated frequency meter
package freq_meter_pkg;

    localparam int CLK_HZ      = 100_000_000;
    localparam int FREQ_W      = 12;
    localparam int FREQ_MAX    = (1 << FREQ_W) - 1;
    localparam int FILL_CYCLES = 2;

    typedef enum logic {
        FILL    = 1'b0,
        MEASURE = 1'b1
    } meter_state_e;

    function automatic int gate_cnt_w(input int gate_cycles);
        return (gate_cycles > 2) ? $clog2(gate_cycles) : 1;
    endfunction

endpackage

// File: rtl/input_sync_edge.sv
// rtl/input_sync_edge.sv - two-flop synchronizer with rising-edge detect for an asynchronous input
module input_sync_edge (
    input  logic CLK,
    input  logic reset_n,
    input  logic IN,
    output logic rise
);

    logic sync1_q;
    logic sync1_d;
    logic sync2_q;
    logic sync2_d;
    logic prev_q;
    logic prev_d;

    always_comb begin
        sync1_d = IN;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/gated_freq_meter.sv
// rtl/gated_freq_meter.sv - counts synchronized IN rising edges per gate window, saturating result word
module gated_freq_meter #(
    parameter int CLK_HZ      = freq_meter_pkg::CLK_HZ,
    parameter int GATE_CYCLES = CLK_HZ,
    parameter int FREQ_W      = freq_meter_pkg::FREQ_W
) (
    input  logic              CLK,
    input  logic              reset_n,
    input  logic              IN,
    output logic [FREQ_W-1:0] freq,
    output logic              freq_valid,
    output logic              overflow
);

    import freq_meter_pkg::*;

    localparam int                GW        = gate_cnt_w(GATE_CYCLES);
    localparam logic [GW-1:0]     GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [FREQ_W-1:0] CNT_MAX   = {FREQ_W{1'b1}};
    localparam logic [1:0]        FILL_LAST = 2'(FILL_CYCLES - 1);

    logic rise;

    meter_state_e      state_q;
    meter_state_e      state_d;
    logic [1:0]        fill_q;
    logic [1:0]        fill_d;
    logic [GW-1:0]     gate_q;
    logic [GW-1:0]     gate_d;
    logic [FREQ_W-1:0] edge_q;
    logic [FREQ_W-1:0] edge_d;
    logic              sat_q;
    logic              sat_d;
    logic [FREQ_W-1:0] freq_q;
    logic [FREQ_W-1:0] freq_d;
    logic              valid_q;
    logic              valid_d;
    logic              ovf_q;
    logic              ovf_d;

    logic              measure_en;
    logic              terminal;
    logic              bump;
    logic              sat_hit;
    logic [FREQ_W-1:0] edge_inc;

    input_sync_edge u_in_sync (
        .CLK     (CLK),
        .reset_n (reset_n),
        .IN      (IN),
        .rise    (rise)
    );

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FILL;
            fill_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    // FILL covers the cycles in which the synchronizer still holds its reset value.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        case (state_q)
            FILL: begin
                if (fill_q == FILL_LAST) begin
                    state_d = MEASURE;
                end else begin
                    fill_d = fill_q + 2'd1;
                end
            end
            MEASURE: state_d = MEASURE;
        endcase
    end

    always_comb begin
        measure_en = (state_q == MEASURE);
        terminal   = measure_en && (gate_q == GATE_LAST);
    end

    always_comb begin
        bump     = measure_en & rise;
        sat_hit  = bump & (edge_q == CNT_MAX);
        edge_inc = (bump && !sat_hit) ? edge_q + 1'b1 : edge_q;
    end

    // The terminal cycle's own rise folds into the closing window before the counter clears.
    always_comb begin
        gate_d  = '0;
        edge_d  = '0;
        sat_d   = 1'b0;
        freq_d  = freq_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        if (terminal) begin
            freq_d  = edge_inc;
            ovf_d   = sat_q | sat_hit;
            valid_d = 1'b1;
        end else if (measure_en) begin
            gate_d = gate_q + 1'b1;
            edge_d = edge_inc;
            sat_d  = sat_q | sat_hit;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            gate_q  <= '0;
            edge_q  <= '0;
            sat_q   <= 1'b0;
            freq_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            gate_q  <= gate_d;
            edge_q  <= edge_d;
            sat_q   <= sat_d;
            freq_q  <= freq_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign freq       = freq_q;
    assign freq_valid = valid_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_gated_freq_meter.sv
// tb/tb_gated_freq_meter.sv - scoreboard bench for gated_freq_meter with two gate lengths
module tb_gated_freq_meter;

    localparam int G_A  = 1000;
    localparam int G_B  = 10000;
    localparam int FW   = 12;
    localparam int FMAX = (1 << FW) - 1;

    localparam int M_LOW   = 0;
    localparam int M_HIGH  = 1;
    localparam int M_TOG   = 2;
    localparam int M_BND   = 3;
    localparam int M_RAND  = 4;
    localparam int M_ASYNC = 5;

    typedef struct {
        int cnt;
        int term;
        bit tol;
    } exp_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_a  = 1'b0;
    logic          in_b  = 1'b0;
    logic [FW-1:0] freq_a;
    logic [FW-1:0] freq_b;
    logic          valid_a;
    logic          valid_b;
    logic          ovf_a;
    logic          ovf_b;

    int n_checks = 0;
    int n_errors = 0;
    int e_cnt    = 0;
    int mode[2]  = '{M_LOW, M_LOW};
    int hp[2]    = '{5, 1};
    int acc[2]   = '{0, 0};
    int dw[2]    = '{0, 0};
    bit tol_win[2] = '{1'b0, 1'b0};
    int last_f[2]  = '{0, 0};
    exp_t sb_a[$];
    exp_t sb_b[$];

    gated_freq_meter #(.GATE_CYCLES(G_A)) u_dut_a (
        .CLK        (clk),
        .reset_n    (rst_n),
        .IN         (in_a),
        .freq       (freq_a),
        .freq_valid (valid_a),
        .overflow   (ovf_a)
    );

    gated_freq_meter #(.GATE_CYCLES(G_B)) u_dut_b (
        .CLK        (clk),
        .reset_n    (rst_n),
        .IN         (in_b),
        .freq       (freq_b),
        .freq_valid (valid_b),
        .overflow   (ovf_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sb_size(input int k);
        return (k == 0) ? sb_a.size() : sb_b.size();
    endfunction

    function automatic exp_t sb_front(input int k);
        return (k == 0) ? sb_a[0] : sb_b[0];
    endfunction

    function automatic void sb_pop(input int k);
        if (k == 0) void'(sb_a.pop_front());
        else        void'(sb_b.pop_front());
    endfunction

    function automatic void sb_push(input int k, input int cnt, input int term, input bit tol);
        exp_t x;
        x.cnt  = cnt;
        x.term = term;
        x.tol  = tol;
        if (k == 0) sb_a.push_back(x);
        else        sb_b.push_back(x);
    endfunction

    // A level change driven after edge e reaches the counter on edge e+3, i.e. window e/G.
    task automatic step(input int k);
        int   g;
        logic cur;
        logic nv;
        g = (k == 0) ? G_A : G_B;
        if (e_cnt / g > dw[k]) begin
            sb_push(k, acc[k], 2 + g * (dw[k] + 1), tol_win[k]);
            acc[k]     = 0;
            dw[k]      = dw[k] + 1;
            tol_win[k] = 1'b0;
        end
        if (mode[k] == M_ASYNC) begin
            tol_win[k] = 1'b1;
            return;
        end
        cur = (k == 0) ? in_a : in_b;
        case (mode[k])
            M_HIGH:  nv = 1'b1;
            M_TOG:   nv = ((e_cnt / hp[k]) % 2) == 1;
            M_BND:   nv = (e_cnt % 20) == 19;
            M_RAND:  nv = 1'($urandom_range(0, 1));
            default: nv = 1'b0;
        endcase
        if (nv && !cur) acc[k]++;
        if (k == 0) in_a = nv;
        else        in_b = nv;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                e_cnt   = 0;
                acc     = '{0, 0};
                dw      = '{0, 0};
                tol_win = '{1'b0, 1'b0};
                last_f  = '{0, 0};
                sb_a.delete();
                sb_b.delete();
            end else begin
                e_cnt++;
                for (int k = 0; k < 2; k++) step(k);
            end
        end
    end

    // Toggles off the clock grid (edge+3ns, then every 35ns) for a CLK/7 input.
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n && mode[0] == M_ASYNC) begin
                #3;
                while (mode[0] == M_ASYNC && rst_n) begin
                    if (!in_a) acc[0]++;
                    in_a = ~in_a;
                    #35;
                end
            end
        end
    end

    task automatic mon(input int k, input logic v, input logic [FW-1:0] f, input logic o);
        exp_t  x;
        string nm;
        int    ef;
        int    d;
        nm = (k == 0) ? "a" : "b";
        while (sb_size(k) > 0 && sb_front(k).term < e_cnt) begin
            x = sb_front(k);
            check({nm, "_missed_valid_edge"}, e_cnt, x.term);
            sb_pop(k);
        end
        if (v) begin
            if (sb_size(k) == 0) begin
                check({nm, "_unexpected_valid"}, 32'(v), 0);
            end else begin
                x = sb_front(k);
                sb_pop(k);
                ef = (x.cnt > FMAX) ? FMAX : x.cnt;
                check({nm, "_valid_edge"}, e_cnt, x.term);
                if (x.tol) begin
                    d = int'(f) - ef;
                    check({nm, "_freq_within_1"}, 32'((d <= 1) && (d >= -1)), 1);
                end else begin
                    check({nm, "_freq"}, 32'(f), ef);
                end
                check({nm, "_overflow"}, 32'(o), 32'(x.cnt > FMAX));
                check({nm, "_no_x"}, 32'($isunknown({v, f, o})), 0);
                last_f[k] = int'(f);
            end
        end else if (e_cnt % 97 == 0) begin
            check({nm, "_freq_hold"}, 32'(f), last_f[k]);
            check({nm, "_no_x"}, 32'($isunknown({v, f, o})), 0);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                mon(0, valid_a, freq_a, ovf_a);
                mon(1, valid_b, freq_b, ovf_b);
            end
        end
    end

    task automatic wait_e(input int n);
        int guard;
        guard = 0;
        while (e_cnt < n) begin
            @(negedge clk);
            guard++;
            if (guard > 40000) begin
                check("wait_edge_timeout", e_cnt, n);
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_freq_a"},  32'(freq_a),  0);
        check({tag, "_valid_a"}, 32'(valid_a), 0);
        check({tag, "_ovf_a"},   32'(ovf_a),   0);
        check({tag, "_freq_b"},  32'(freq_b),  0);
        check({tag, "_valid_b"}, 32'(valid_b), 0);
        check({tag, "_ovf_b"},   32'(ovf_b),   0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n   = 1'b1;
        mode[0] = M_TOG;
        mode[1] = M_TOG;

        wait_e(3000);
        mode[0] = M_LOW;
        wait_e(5000);
        mode[0] = M_HIGH;
        wait_e(7000);
        mode[0] = M_BND;
        wait_e(9000);
        mode[0] = M_RAND;
        hp[1]   = 5;
        wait_e(12000);
        mode[0] = M_TOG;
        hp[0]   = 3;
        wait_e(14000);
        mode[0] = M_ASYNC;
        wait_e(17000);
        mode[0] = M_TOG;
        hp[0]   = 5;
        wait_e(20600);

        @(posedge clk);
        #2;
        mode = '{M_LOW, M_LOW};
        in_a = 1'b0;
        in_b = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        mode[0] = M_TOG;
        wait_e(3010);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gated_freq_meter.md
# gated_freq_meter

Upstream measurement stage of the frequency-display path: synchronizes the external square-wave input `IN` into the `CLK` domain, counts its rising edges over a fixed gate window (1 s at 100 MHz by default), and presents a registered 12-bit frequency word. Downstream, the binary-to-BCD converter and the seven-segment display controller consume this word. A one-cycle `freq_valid` strobe and an `overflow` flag accompany each new result.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency in Hz.
- `GATE_CYCLES`, `CLK_HZ`, gate window length in `CLK` cycles. Must be ≥ 4. Benches override it with a small value.
- `FREQ_W`, 12, width of the result word.
- `CLK` in 1: system clock, 100 MHz on Basys 3.
- `reset_n` in 1: asynchronous, active-low reset.
- `IN` in 1: asynchronous external signal being measured.
- `freq` out `FREQ_W`: rising-edge count of the last completed window, saturated.
- `freq_valid` out 1: one-cycle pulse when `freq` updates.
- `overflow` out 1: high if the last completed window saturated.

## Operation
- Input path:
  - 2-flop synchronizer on `IN`, then a third register for edge detection.
  - `rise` = synchronized value high and previous value low.
- FSM states:
  - `FILL`: entered on reset. Lasts exactly 2 cycles while the synchronizer fills. `rise` is ignored and the gate counter is held at 0. Transitions to `MEASURE`.
  - `MEASURE`: the gate counter counts 0 … `GATE_CYCLES`-1 and wraps. The FSM stays in `MEASURE` until reset.
- Edge counter (`FREQ_W` bits):
  - Increments on `rise` in `MEASURE`.
  - Saturates at 2^`FREQ_W`-1 (4095).
  - A `sat` flag is set when an increment is attempted at the maximum value.
- Terminal cycle (gate counter = `GATE_CYCLES`-1):
  - `freq` ← edge count plus that cycle's `rise`, saturated.
  - `overflow` ← `sat`, including saturation caused on the terminal cycle itself.
  - `freq_valid` ← 1 for one cycle.
  - Edge counter ← 0 and `sat` ← 0 for the next window.
  - Net effect: an edge on the terminal cycle belongs to the closing window, and no edge is lost or double-counted across the window boundary.
- `freq` and `overflow` hold their values between terminal cycles.
- Reset asserted at any time, including mid-window:
  - All state clears immediately.
  - The partial window is discarded.
  - The FSM returns to `FILL`.

## Timing
- Reset values: `freq`=0, `freq_valid`=0, `overflow`=0, FSM=`FILL`, all counters 0, synchronizer flops 0.
- Edge-to-count latency: a rising edge of `IN` increments the counter 3 `CLK` edges later (2 synchronizer flops plus the edge register).
- First `freq_valid` asserts in cycle 2+`GATE_CYCLES` after `reset_n` deasserts, counting the first rising `CLK` edge after release as cycle 1.
- After that, `freq_valid` repeats exactly every `GATE_CYCLES` cycles.
- `freq`, `overflow` and `freq_valid` update on the same clock edge.
- There is no backpressure: consumers sample `freq` whenever they need it.
- Measurable range:
  - Maximum input frequency is below `CLK_HZ`/2; it requires a high and a low phase each ≥ 1 cycle.
  - Counts above 4095 per window report 4095 with `overflow`=1.
- Gate counter width: clog2(`GATE_CYCLES`) bits.

## Structure
- Shared package `freq_meter_pkg`:
  - Default constants `CLK_HZ`, `FREQ_W`.
  - FSM state encoding (`FILL`, `MEASURE`).
  - `FREQ_MAX` = 2^`FREQ_W`-1.
- Sub-module `input_sync_edge`: 2-flop synchronizer plus rising-edge detector, async active-low reset. Ports: `CLK`, `reset_n`, `IN`, `rise`. It is reused by any other asynchronous input in the design.
- The top module holds the FSM, gate counter, saturating edge counter and output registers.

## Test plan
- `GATE_CYCLES`=1000, `IN` toggles every 5 cycles (period 10) → each `freq_valid` shows `freq`=100, `overflow`=0. Pulses are spaced exactly 1000 cycles apart; the first arrives at cycle 1002.
- `IN` held at 0, then held at 1 → `freq`=0 every window. A single 0→1 transition produces `freq`=1 in exactly one window.
- `GATE_CYCLES`=10000, `IN` period 2 (5000 edges/window) → `freq`=4095, `overflow`=1. Switching `IN` to period 10 gives `freq`=1000, `overflow`=0 in the next full window.
- Boundary edge: place an `IN` rise so that `rise` lands exactly on the terminal cycle → it is counted in the closing window (e.g. 50 → 51) and the next window starts at 0. Total edges over N windows equals the stimulus count exactly.
- Reset mid-window: assert `reset_n`=0 at cycle 600 of a window → outputs read 0 immediately. After release, the next `freq_valid` appears at cycle 1002 with a full-window count, and no partial-window result is ever emitted.
- Glitch check: toggle `IN` asynchronously (not aligned to `CLK`) at `CLK_HZ`/7 → count stays within ±1 of expected, with no X on any output.
